// File: rtl/bus_timer_irq_if.sv
// bus_timer_irq_if: CPU-side bus bundle for bus_timer_irq.
// The CPU (or bench) drives address/write/data_i; the timer returns
// registered read data with a one-cycle-late data_valid qualifier.
interface bus_timer_irq_if;
   logic [15:0] address;
   logic        write;
   logic [7:0]  data_i;
   logic [7:0]  data_o;
   logic        data_valid;

   modport master (
      output address,
      output write,
      output data_i,
      input  data_o,
      input  data_valid
   );

   modport slave (
      input  address,
      input  write,
      input  data_i,
      output data_o,
      output data_valid
   );
endinterface

// File: rtl/bus_timer_irq.sv
// bus_timer_irq: memory-mapped 16-bit interval timer and interrupt source.
// Decodes an 8-byte window at BASE[15:3], takes register writes on the edge
// ending a selected write cycle, returns registered read data one cycle after
// a selected read cycle, and drives a registered level irq from the timer
// flag (TF/TIE) and the software flag (SF/SIE).
// Optional feature macro: BUS_TIMER_PRESCALER_EN enables the 8-bit prescaler
// (register 5). Without it the timer ticks every enabled clock and register 5
// reads 0 and ignores writes.
module bus_timer_irq #(
   parameter logic [15:0] BASE = 16'hD000
) (
   input  logic           clk,
   input  logic           reset,
   bus_timer_irq_if.slave bus,
   output logic           irq
);

   localparam logic [2:0] REG_TLO   = 3'd0;
   localparam logic [2:0] REG_THI   = 3'd1;
   localparam logic [2:0] REG_CTRL  = 3'd2;
   localparam logic [2:0] REG_STAT  = 3'd3;
   localparam logic [2:0] REG_SOFT  = 3'd4;
   localparam logic [2:0] REG_PRESC = 3'd5;

   // Architectural state
   logic [15:0] latch_r;
   logic [15:0] count_r;
   logic        en_r;
   logic        cont_r;
   logic        tie_r;
   logic        sie_r;
   logic        tf_r;
   logic        sf_r;
   logic [7:0]  snap_r;
   logic [7:0]  data_o_r;
   logic        data_valid_r;
   logic        irq_r;
`ifdef BUS_TIMER_PRESCALER_EN
   logic [7:0]  presc_r;
   logic [7:0]  pcnt_r;
   logic [7:0]  presc_s;
   logic [7:0]  pcnt_s;
   logic        wr_presc_s;
`endif

   // Decode strobes
   logic        sel_s;
   logic [2:0]  reg_s;
   logic        rd_s;
   logic        rd_tlo_s;
   logic        wr_tlo_s;
   logic        wr_thi_s;
   logic        wr_ctrl_s;
   logic        wr_stat_s;
   logic        wr_soft_s;

   // Timer events
   logic        tick_s;
   logic        expire_s;

   // Next-state values
   logic [15:0] latch_s;
   logic [15:0] count_s;
   logic        en_s;
   logic        cont_s;
   logic        tie_s;
   logic        sie_s;
   logic        tf_s;
   logic        sf_s;
   logic [7:0]  snap_s;
   logic [7:0]  rdata_s;
   logic [7:0]  data_o_s;
   logic        irq_s;

   // Window decode and per-register read/write strobes for the current cycle.
   always_comb begin
      sel_s     = (bus.address[15:3] == BASE[15:3]);
      reg_s     = bus.address[2:0];
      rd_s      = sel_s & ~bus.write;
      rd_tlo_s  = rd_s & (reg_s == REG_TLO);
      wr_tlo_s  = sel_s & bus.write & (reg_s == REG_TLO);
      wr_thi_s  = sel_s & bus.write & (reg_s == REG_THI);
      wr_ctrl_s = sel_s & bus.write & (reg_s == REG_CTRL);
      wr_stat_s = sel_s & bus.write & (reg_s == REG_STAT);
      wr_soft_s = sel_s & bus.write & (reg_s == REG_SOFT);
`ifdef BUS_TIMER_PRESCALER_EN
      wr_presc_s = sel_s & bus.write & (reg_s == REG_PRESC);
`endif
   end

   // Tick generation (prescaler compare or every enabled clock) and expiry detect.
   always_comb begin
`ifdef BUS_TIMER_PRESCALER_EN
      tick_s = en_r & (pcnt_r == presc_r);
`else
      tick_s = en_r;
`endif
      expire_s = tick_s & (count_r == 16'h0000);
   end

`ifdef BUS_TIMER_PRESCALER_EN
   // Prescaler counter and prescale register next state; a THI write restarts the prescale phase.
   always_comb begin
      if (wr_thi_s | ~en_r | tick_s) begin
         pcnt_s = 8'h00;
      end else begin
         pcnt_s = pcnt_r + 8'h01;
      end
      if (wr_presc_s) begin
         presc_s = bus.data_i;
      end else begin
         presc_s = presc_r;
      end
   end
`endif

   // Reload latch and down-counter next state; a THI write overrides any tick or expiry.
   always_comb begin
      latch_s = latch_r;
      if (wr_tlo_s) begin
         latch_s[7:0] = bus.data_i;
      end else if (wr_thi_s) begin
         latch_s[15:8] = bus.data_i;
      end else begin
         latch_s = latch_r;
      end

      if (wr_thi_s) begin
         count_s = {bus.data_i, latch_r[7:0]};
      end else if (tick_s) begin
         if (count_r != 16'h0000) begin
            count_s = count_r - 16'h0001;
         end else if (cont_r) begin
            count_s = latch_r;
         end else begin
            count_s = 16'h0000;
         end
      end else begin
         count_s = count_r;
      end
   end

   // Status flags: THI write discards a coincident expiry, and a set beats a coincident STAT clear.
   always_comb begin
      if (wr_thi_s) begin
         tf_s = 1'b0;
      end else if (expire_s) begin
         tf_s = 1'b1;
      end else if (wr_stat_s & bus.data_i[0]) begin
         tf_s = 1'b0;
      end else begin
         tf_s = tf_r;
      end

      if (wr_soft_s) begin
         sf_s = 1'b1;
      end else if (wr_stat_s & bus.data_i[1]) begin
         sf_s = 1'b0;
      end else begin
         sf_s = sf_r;
      end
   end

   // Control bits: a CTRL write beats the one-shot auto-clear of EN.
   always_comb begin
      en_s   = en_r;
      cont_s = cont_r;
      tie_s  = tie_r;
      sie_s  = sie_r;
      if (wr_ctrl_s) begin
         en_s   = bus.data_i[0];
         cont_s = bus.data_i[1];
         tie_s  = bus.data_i[2];
         sie_s  = bus.data_i[3];
      end else if (expire_s & ~cont_r & ~wr_thi_s) begin
         en_s = 1'b0;
      end else begin
         en_s = en_r;
      end
   end

   // Read mux, TLO snapshot capture and irq next-state from pre-edge register values.
   always_comb begin
      case (reg_s)
         REG_TLO:   rdata_s = count_r[7:0];
         REG_THI:   rdata_s = snap_r;
         REG_CTRL:  rdata_s = {4'b0000, sie_r, tie_r, cont_r, en_r};
         REG_STAT:  rdata_s = {irq_r, 5'b00000, sf_r, tf_r};
`ifdef BUS_TIMER_PRESCALER_EN
         REG_PRESC: rdata_s = presc_r;
`else
         REG_PRESC: rdata_s = 8'h00;
`endif
         default:   rdata_s = 8'h00;
      endcase

      if (rd_s) begin
         data_o_s = rdata_s;
      end else begin
         data_o_s = 8'h00;
      end

      if (rd_tlo_s) begin
         snap_s = count_r[15:8];
      end else begin
         snap_s = snap_r;
      end

      irq_s = (tf_r & tie_r) | (sf_r & sie_r);
   end

   // State and registered-output update with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         latch_r      <= 16'hFFFF;
         count_r      <= 16'hFFFF;
         en_r         <= 1'b0;
         cont_r       <= 1'b0;
         tie_r        <= 1'b0;
         sie_r        <= 1'b0;
         tf_r         <= 1'b0;
         sf_r         <= 1'b0;
         snap_r       <= 8'h00;
         data_o_r     <= 8'h00;
         data_valid_r <= 1'b0;
         irq_r        <= 1'b0;
`ifdef BUS_TIMER_PRESCALER_EN
         presc_r      <= 8'h00;
         pcnt_r       <= 8'h00;
`endif
      end else begin
         latch_r      <= latch_s;
         count_r      <= count_s;
         en_r         <= en_s;
         cont_r       <= cont_s;
         tie_r        <= tie_s;
         sie_r        <= sie_s;
         tf_r         <= tf_s;
         sf_r         <= sf_s;
         snap_r       <= snap_s;
         data_o_r     <= data_o_s;
         data_valid_r <= rd_s;
         irq_r        <= irq_s;
`ifdef BUS_TIMER_PRESCALER_EN
         presc_r      <= presc_s;
         pcnt_r       <= pcnt_s;
`endif
      end
   end

   assign bus.data_o     = data_o_r;
   assign bus.data_valid = data_valid_r;
   assign irq            = irq_r;

endmodule

// File: tb/tb_bus_timer_irq.sv
// tb_bus_timer_irq: directed plus randomized bench for bus_timer_irq.
// A behavioural model (integer arithmetic, sequential event rules) predicts
// data_o, data_valid and irq after every clock edge; directed steps add
// fixed expectations for the documented scenarios.
module tb_bus_timer_irq;

   localparam logic [15:0] BASE   = 16'hD000;
   localparam logic [15:0] A_TLO  = 16'hD000;
   localparam logic [15:0] A_THI  = 16'hD001;
   localparam logic [15:0] A_CTRL = 16'hD002;
   localparam logic [15:0] A_STAT = 16'hD003;
   localparam logic [15:0] A_SOFT = 16'hD004;
   localparam logic [15:0] A_PRE  = 16'hD005;
   localparam logic [15:0] IDLE   = 16'h0200;
`ifdef BUS_TIMER_PRESCALER_EN
   localparam bit PRESC_ON = 1'b1;
`else
   localparam bit PRESC_ON = 1'b0;
`endif

   logic clk;
   logic reset;
   logic irq;
   bus_timer_irq_if bif ();

   bus_timer_irq #(.BASE(BASE)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif),
      .irq   (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit rst_v;

   // Behavioural model state
   int m_latch, m_count, m_presc, m_pcnt, m_snap, m_dout;
   bit m_en, m_cont, m_tie, m_sie, m_tf, m_sf, m_valid, m_irq;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int presc_eff();
      return PRESC_ON ? m_presc : 0;
   endfunction

   function automatic bit model_expiry_next();
      return m_en && (m_pcnt == presc_eff()) && (m_count == 0);
   endfunction

   task automatic model_reset();
      m_latch = 65535; m_count = 65535; m_presc = 0; m_pcnt = 0; m_snap = 0;
      m_en = 0; m_cont = 0; m_tie = 0; m_sie = 0; m_tf = 0; m_sf = 0;
      m_dout = 0; m_valid = 0; m_irq = 0;
   endtask

   task automatic model_step(input logic [15:0] a, input logic w, input logic [7:0] d);
      int off, n_latch, n_count, n_pcnt, n_presc, n_snap;
      bit hit, tick, expire, n_en, n_cont, n_tie, n_sie, n_tf, n_sf, n_irq;
      off = int'(a) - int'(BASE);
      hit = (off >= 0) && (off <= 7);
      n_latch = m_latch; n_count = m_count; n_pcnt = m_pcnt; n_presc = m_presc;
      n_snap = m_snap; n_en = m_en; n_cont = m_cont; n_tie = m_tie; n_sie = m_sie;
      n_tf = m_tf; n_sf = m_sf;
      n_irq = (m_tf && m_tie) || (m_sf && m_sie);
      // read path sees the state before the edge
      m_valid = hit && !w;
      m_dout = 0;
      if (hit && !w) begin
         case (off)
            0: begin m_dout = m_count % 256; n_snap = m_count / 256; end
            1: m_dout = m_snap;
            2: m_dout = m_en + 2 * m_cont + 4 * m_tie + 8 * m_sie;
            3: m_dout = (m_irq ? 128 : 0) + (m_sf ? 2 : 0) + (m_tf ? 1 : 0);
            5: m_dout = PRESC_ON ? m_presc : 0;
            default: m_dout = 0;
         endcase
      end
      // timer events
      tick = m_en && (m_pcnt == presc_eff());
      expire = tick && (m_count == 0);
      n_pcnt = (m_en && !tick) ? m_pcnt + 1 : 0;
      if (tick && !expire) n_count = m_count - 1;
      if (expire) begin
         n_tf = 1;
         if (m_cont) n_count = m_latch;
         else n_en = 0;
      end
      // bus writes applied last so they override timer effects where they should
      if (hit && w) begin
         case (off)
            0: n_latch = (m_latch / 256) * 256 + int'(d);
            1: begin
               n_latch = int'(d) * 256 + m_latch % 256;
               n_count = n_latch; n_tf = 0; n_en = m_en; n_pcnt = 0;
            end
            2: begin n_en = d[0]; n_cont = d[1]; n_tie = d[2]; n_sie = d[3]; end
            3: begin
               if (d[0] && !expire) n_tf = 0;
               if (d[1]) n_sf = 0;
            end
            4: n_sf = 1;
            5: if (PRESC_ON) n_presc = int'(d);
            default: ;
         endcase
      end
      m_latch = n_latch; m_count = n_count; m_pcnt = n_pcnt; m_presc = n_presc;
      m_snap = n_snap; m_en = n_en; m_cont = n_cont; m_tie = n_tie; m_sie = n_sie;
      m_tf = n_tf; m_sf = n_sf; m_irq = n_irq;
   endtask

   task automatic step(input logic [15:0] a, input logic w, input logic [7:0] d);
      @(negedge clk);
      bif.address = a;
      bif.write   = w;
      bif.data_i  = d;
      reset       = rst_v;
      if (rst_v) model_reset();
      else model_step(a, w, d);
      @(posedge clk);
      #1;
      chk("model_data_o", bif.data_o, 16'(m_dout));
      chk("model_data_valid", bif.data_valid, 16'(m_valid));
      chk("model_irq", irq, 16'(m_irq));
   endtask

   task automatic wait_expiry(input string tag);
      int n;
      n = 0;
      while (!model_expiry_next() && n < 40) begin
         step(IDLE, 1'b0, 8'h00);
         n++;
      end
      chk(tag, model_expiry_next(), 1'b1);
   endtask

   logic [7:0]  rst_exp [6];
   logic [15:0] ra;
   logic        rw;
   logic [7:0]  rd;
   int          n, sel, period_exp;
   bit          seen_low;

   initial begin
      rst_exp = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
      reset = 1'b1;
      bif.address = IDLE;
      bif.write = 1'b0;
      bif.data_i = 8'h00;
      model_reset();

      // reset for two cycles, then read registers 0..5
      rst_v = 1'b1;
      step(IDLE, 1'b0, 8'h00);
      step(IDLE, 1'b0, 8'h00);
      chk("rst_irq", irq, 1'b0);
      chk("rst_valid", bif.data_valid, 1'b0);
      rst_v = 1'b0;
      for (int r = 0; r < 6; r++) begin
         step(A_TLO + 16'(r), 1'b0, 8'h00);
         chk("rst_read_valid", bif.data_valid, 1'b1);
         chk("rst_read_val", bif.data_o, rst_exp[r]);
      end
      step(IDLE, 1'b0, 8'h00);
      chk("idle_valid", bif.data_valid, 1'b0);
      chk("idle_data", bif.data_o, 8'h00);

      // one-shot: latch 3, CTRL=05 at edge E
      step(A_TLO, 1'b1, 8'h03);
      step(A_THI, 1'b1, 8'h00);
      step(A_CTRL, 1'b1, 8'h05);
      for (int k = 1; k <= 4; k++) begin
         step(IDLE, 1'b0, 8'h00);
         chk("oneshot_irq_early", irq, 1'b0);
      end
      step(IDLE, 1'b0, 8'h00);
      chk("oneshot_irq_rise", irq, 1'b1);
      step(A_CTRL, 1'b0, 8'h00);
      chk("oneshot_ctrl", bif.data_o, 8'h04);
      step(A_TLO, 1'b0, 8'h00);
      chk("oneshot_cnt_lo", bif.data_o, 8'h00);
      step(A_THI, 1'b0, 8'h00);
      chk("oneshot_cnt_hi", bif.data_o, 8'h00);
      step(A_STAT, 1'b1, 8'h01);
      chk("oneshot_irq_hold", irq, 1'b1);
      step(IDLE, 1'b0, 8'h00);
      chk("oneshot_irq_clr", irq, 1'b0);

      // continuous mode, period measured on irq rises
      step(A_TLO, 1'b1, 8'h02);
      step(A_THI, 1'b1, 8'h00);
      step(A_PRE, 1'b1, 8'h01);
      step(A_CTRL, 1'b1, 8'h07);
      period_exp = 3 * (PRESC_ON ? 2 : 1);
      n = 0;
      while (irq !== 1'b1 && n < 40) begin
         step(IDLE, 1'b0, 8'h00);
         n++;
      end
      chk("cont_first_irq", irq, 1'b1);
      step(A_STAT, 1'b1, 8'h01);
      n = 1;
      seen_low = 1'b0;
      while (n < 40 && !(seen_low && irq === 1'b1)) begin
         if (irq === 1'b0) seen_low = 1'b1;
         step(IDLE, 1'b0, 8'h00);
         n++;
      end
      chk("cont_period", 16'(n), 16'(period_exp));
      wait_expiry("cont_find_exp");
      step(A_STAT, 1'b1, 8'h01);
      step(A_STAT, 1'b0, 8'h00);
      chk("stat_clr_vs_set", bif.data_o[0], 1'b1);
      step(A_CTRL, 1'b1, 8'h00);
      step(A_STAT, 1'b1, 8'h03);

      // snapshot: counter 0100 ticking every cycle
      step(A_PRE, 1'b1, 8'h00);
      step(A_TLO, 1'b1, 8'h00);
      step(A_CTRL, 1'b1, 8'h01);
      step(A_THI, 1'b1, 8'h01);
      step(A_TLO, 1'b0, 8'h00);
      chk("snap_lo", bif.data_o, 8'h00);
      step(IDLE, 1'b0, 8'h00);
      step(IDLE, 1'b0, 8'h00);
      step(A_THI, 1'b0, 8'h00);
      chk("snap_hi", bif.data_o, 8'h01);
      step(A_CTRL, 1'b1, 8'h00);

      // software interrupt
      step(A_CTRL, 1'b1, 8'h08);
      step(A_SOFT, 1'b1, 8'h5A);
      chk("soft_irq_lag", irq, 1'b0);
      step(IDLE, 1'b0, 8'h00);
      chk("soft_irq", irq, 1'b1);
      step(A_STAT, 1'b1, 8'h02);
      step(IDLE, 1'b0, 8'h00);
      chk("soft_irq_clr", irq, 1'b0);
      step(A_CTRL, 1'b1, 8'h00);
      step(A_SOFT, 1'b1, 8'h00);
      step(IDLE, 1'b0, 8'h00);
      step(IDLE, 1'b0, 8'h00);
      chk("soft_masked_irq", irq, 1'b0);
      step(A_STAT, 1'b0, 8'h00);
      chk("soft_masked_sf", bif.data_o, 8'h02);
      step(A_STAT, 1'b1, 8'h02);

      // decode boundaries
      step(16'hCFFF, 1'b1, 8'hFF);
      step(16'hD008, 1'b1, 8'h0F);
      step(16'hD00A, 1'b1, 8'h0F);
      step(16'hCFFF, 1'b0, 8'h00);
      chk("dec_lo_valid", bif.data_valid, 1'b0);
      step(16'hD008, 1'b0, 8'h00);
      chk("dec_hi_valid", bif.data_valid, 1'b0);
      step(A_CTRL, 1'b0, 8'h00);
      chk("dec_ctrl", bif.data_o, 8'h00);

      // THI write coincident with expiry
      step(A_TLO, 1'b1, 8'h02);
      step(A_THI, 1'b1, 8'h00);
      step(A_PRE, 1'b1, 8'h00);
      step(A_CTRL, 1'b1, 8'h03);
      wait_expiry("thi_find_exp");
      step(A_THI, 1'b1, 8'h01);
      step(A_TLO, 1'b0, 8'h00);
      chk("thi_win_cnt_lo", bif.data_o, 8'h02);
      step(A_THI, 1'b0, 8'h00);
      chk("thi_win_cnt_hi", bif.data_o, 8'h01);
      step(A_STAT, 1'b0, 8'h00);
      chk("thi_win_tf", bif.data_o[0], 1'b0);

      // CTRL write coincident with one-shot auto-clear
      step(A_CTRL, 1'b1, 8'h00);
      step(A_TLO, 1'b1, 8'h01);
      step(A_THI, 1'b1, 8'h00);
      step(A_CTRL, 1'b1, 8'h01);
      wait_expiry("ctrl_find_exp");
      step(A_CTRL, 1'b1, 8'h07);
      step(A_CTRL, 1'b0, 8'h00);
      chk("ctrl_win", bif.data_o, 8'h07);

      // reset mid-count with irq asserted
      step(IDLE, 1'b0, 8'h00);
      step(IDLE, 1'b0, 8'h00);
      chk("pre_rst_irq", irq, 1'b1);
      rst_v = 1'b1;
      step(IDLE, 1'b0, 8'h00);
      rst_v = 1'b0;
      chk("rst_mid_irq", irq, 1'b0);
      step(A_TLO, 1'b0, 8'h00);
      chk("rst_mid_cnt", bif.data_o, 8'hFF);
      step(A_CTRL, 1'b0, 8'h00);
      chk("rst_mid_ctrl", bif.data_o, 8'h00);
      step(A_STAT, 1'b0, 8'h00);
      chk("rst_mid_stat", bif.data_o, 8'h00);

      // randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         sel = $urandom_range(0, 15);
         if (sel == 0) ra = BASE + 16'($urandom_range(8, 40));
         else if (sel == 1) ra = BASE - 16'($urandom_range(1, 40));
         else if (sel < 5) ra = IDLE;
         else ra = BASE + 16'($urandom_range(0, 7));
         rw = 1'($urandom_range(0, 1));
         rd = 8'($urandom);
         if (ra == A_THI && rw) rd = 8'($urandom_range(0, 1));
         if (ra == A_TLO && rw) rd = 8'($urandom_range(0, 12));
         if (ra == A_PRE && rw) rd = 8'($urandom_range(0, 3));
         rst_v = ($urandom_range(0, 149) == 0);
         step(ra, rw, rd);
      end
      rst_v = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
